instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage between the 16-bit program counter and the instruction decoder. Reads the word at the current PC over the shared von Neumann memory read port using a req/ack handshake. Latches the word into an instruction register and presents it downstream with a valid/ready handshake. Pulses the PC increment on each completed fetch and discards in-flight fetches when the control unit redirects the PC.

## Interface
- DATA_W, 16, instruction/data word width
- ADDR_W, 16, memory address width; must equal PC width
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pc_in  input  ADDR_W  current program counter value
- pc_inc  output  1  combinational increment strobe to the program counter
- flush  input  1  redirect; asserted by control in the same cycle it asserts the PC load
- mem_rd_req  output  1  memory read request
- mem_addr  output  ADDR_W  read address, stable while mem_rd_req is high
- mem_rd_ack  input  1  read completion; mem_rd_data is valid in this cycle
- mem_rd_data  input  DATA_W  read data
- instr  output  DATA_W  fetched instruction (registered)
- instr_addr  output  ADDR_W  address the instruction was fetched from (registered)
- instr_valid  output  1  instr/instr_addr are valid
- instr_ready  input  1  decoder accepts instr this cycle

## Operation
- States: IDLE, REQ, DROP, HOLD.
- Internal register fetch_addr drives mem_addr.
- IDLE:
  - fetch_addr <= pc_in.
  - flush low: go to REQ.
  - flush high: stay in IDLE.
- REQ: mem_rd_req = 1.
  - ack=1, flush=0: instr <= mem_rd_data, instr_addr <= fetch_addr, pc_inc = 1; go to HOLD.
  - ack=1, flush=1: data discarded, pc_inc = 0; go to IDLE.
  - ack=0, flush=1: go to DROP.
  - ack=0, flush=0: stay in REQ.
- DROP: mem_rd_req = 1 with the same fetch_addr until ack (the request is never withdrawn); data discarded; on ack go to IDLE. flush in DROP has no further effect.
- HOLD: instr_valid = 1.
  - flush=1: go to IDLE; ready is ignored; the instruction is dropped.
  - ready=1, flush=0: fetch_addr <= pc_in; go to REQ.
  - ready=0: hold; instr and instr_addr stay stable.
- pc_inc = (state==REQ) & mem_rd_ack & !flush.
  - Never high in any other state.
  - Never high in the same cycle as flush, so PC load and increment never collide.
- mem_addr equals fetch_addr in all states. Widths are identical: no arithmetic or wrap handling. PC wrap 0xFFFF→0x0000 is transparent.

## Timing
- Reset (synchronous, priority over everything):
  - state = IDLE
  - mem_rd_req = 0, instr_valid = 0
  - instr = 0, instr_addr = 0, fetch_addr = 0
- Outputs when leaving reset:
  - mem_rd_req rises one cycle after reset deasserts (IDLE → REQ).
  - mem_addr = pc_in sampled in the IDLE cycle.
- Fetch latency: ack in the cycle of request entry gives instr_valid high on the next cycle.
- PC increments on the same edge that latches instr. pc_in is already the next address throughout HOLD.
- Zero-wait memory with instr_ready held high: one instruction per 2 cycles (REQ, HOLD alternate).
- Redirect: flush in cycle N (PC loads at edge N). IDLE in N+1 samples the new pc_in. mem_rd_req for the new target rises in N+2, unless a DROP drain is pending.
- Reset asserted mid-fetch: returns to IDLE immediately. The memory side must tolerate request withdrawal on reset only.

## Test plan
- Reset then zero-wait memory returning mem[a]=a^16'hA5A5, ready=1, PC from 0 → instr sequence 0xA5A5, 0xA5A4, 0xA5A7… with instr_addr 0,1,2; pc_inc pulses every 2nd cycle; valid every other cycle.
- 3-cycle memory wait on address 0x0010 → mem_rd_req high 4 cycles with mem_addr=0x0010 stable; exactly one pc_inc; instr_valid one cycle after ack.
- Backpressure: instr_ready low 5 cycles in HOLD → instr/instr_addr stable, no new mem_rd_req, pc_inc=0 throughout; fetch of next address starts the cycle after ready.
- Flush in REQ before ack (PC loaded 0x0200) → DROP holds old address until ack; no pc_inc, no instr_valid; next request uses mem_addr=0x0200.
- Flush coincident with ack, and flush in HOLD with ready=1 → no pc_inc, instr_valid low next cycle, next fetch from the loaded PC.
- Reset asserted while in REQ and while in HOLD → next cycle mem_rd_req=0, instr_valid=0, instr=0; normal fetch from pc_in=0 resumes.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: reads the word at the current PC over a req/ack memory port,
// registers it with its address and offers it downstream on a valid/ready handshake.
module instruction_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_inc,
    input  logic              flush,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP,
        HOLD
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] fetch_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_addr <= '0;
            instr      <= '0;
            instr_addr <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: fetch_addr <= pc_in;
                REQ: begin
                    if (mem_rd_ack && !flush) begin
                        instr      <= mem_rd_data;
                        instr_addr <= fetch_addr;
                    end
                end
                HOLD: begin
                    if (instr_ready && !flush) begin
                        fetch_addr <= pc_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state  = state;
        mem_rd_req  = 1'b0;
        instr_valid = 1'b0;
        pc_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (!flush) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                mem_rd_req = 1'b1;
                // Increment is suppressed under flush so PC load and increment never collide.
                pc_inc     = mem_rd_ack && !flush;
                if (mem_rd_ack) begin
                    next_state = flush ? IDLE : HOLD;
                end else if (flush) begin
                    next_state = DROP;
                end
            end
            DROP: begin
                // The outstanding request is never withdrawn; its data is simply discarded.
                mem_rd_req = 1'b1;
                if (mem_rd_ack) begin
                    next_state = IDLE;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (flush) begin
                    next_state = IDLE;
                end else if (instr_ready) begin
                    next_state = REQ;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign mem_addr = fetch_addr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: bench-side PC and memory models, a
// scoreboard of expected instructions, and per-cycle handshake checks.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_in;
    logic        pc_inc;
    logic        flush;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic        mem_rd_ack;
    logic [15:0] mem_rd_data;
    logic [15:0] instr;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready;

    logic [15:0] load_val;
    int unsigned mem_wait;
    int unsigned mem_cnt;
    logic        inc_s, fl_s, rst_s;
    logic [15:0] ld_s;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] addr;
    } txn_t;
    txn_t exp_q[$];

    int passed = 0;
    int total  = 0;

    instruction_fetch #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_inc     (pc_inc),
        .flush      (flush),
        .mem_rd_req (mem_rd_req),
        .mem_addr   (mem_addr),
        .mem_rd_ack (mem_rd_ack),
        .mem_rd_data(mem_rd_data),
        .instr      (instr),
        .instr_addr (instr_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Capture the previous cycle's control inputs away from the edge.
    always @(negedge clk) begin
        inc_s = pc_inc;
        fl_s  = flush;
        ld_s  = load_val;
        rst_s = reset;
    end

    // Program counter and memory models, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst_s) pc_in = 16'h0000;
        else if (fl_s) pc_in = ld_s;
        else if (inc_s) pc_in = pc_in + 16'h0001;
        if (mem_rd_req) begin
            if (mem_cnt == mem_wait) begin
                mem_rd_ack  = 1'b1;
                mem_rd_data = mem_addr ^ 16'hA5A5;
                mem_cnt     = 0;
            end else begin
                mem_rd_ack  = 1'b0;
                mem_rd_data = 16'hDEAD;
                mem_cnt     = mem_cnt + 1;
            end
        end else begin
            mem_rd_ack  = 1'b0;
            mem_rd_data = 16'hDEAD;
            mem_cnt     = 0;
        end
    end

    // Scoreboard monitor: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready && !flush) begin
            if (exp_q.size() == 0) begin
                check("unexpected_instr", {instr_addr, instr}, 32'hFFFF_FFFF);
            end else begin
                txn_t t;
                t = exp_q.pop_front();
                check("sb_instr", {16'h0, instr}, {16'h0, t.data});
                check("sb_instr_addr", {16'h0, instr_addr}, {16'h0, t.addr});
            end
        end
    end

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input logic er, input logic ei, input logic ev);
        @(negedge clk);
        check("mem_rd_req", {31'h0, mem_rd_req}, {31'h0, er});
        check("pc_inc", {31'h0, pc_inc}, {31'h0, ei});
        check("instr_valid", {31'h0, instr_valid}, {31'h0, ev});
    endtask

    task automatic chk_addr(input logic [15:0] a);
        check("mem_addr", {16'h0, mem_addr}, {16'h0, a});
    endtask

    task automatic push(input logic [15:0] d, input logic [15:0] a);
        txn_t t;
        t.data = d;
        t.addr = a;
        exp_q.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        instr_ready = 1'b1;
        load_val    = 16'h0000;
        pc_in       = 16'h0000;
        mem_wait    = 0;
        mem_cnt     = 0;
        mem_rd_ack  = 1'b0;
        mem_rd_data = 16'hDEAD;
        inc_s = 1'b0; fl_s = 1'b0; rst_s = 1'b1; ld_s = 16'h0;

        adv; adv;
        @(negedge clk);
        check("rst_req", {31'h0, mem_rd_req}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", {16'h0, instr}, 32'h0);
        check("rst_instr_addr", {16'h0, instr_addr}, 32'h0);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);

        // Zero-wait streaming from PC 0.
        adv; reset = 1'b0; chk3(0, 0, 0);
        for (int a = 0; a < 3; a++) push(16'(a) ^ 16'hA5A5, 16'(a));
        for (int i = 1; i <= 7; i++) begin
            adv;
            chk3(i % 2 == 1, i % 2 == 1, i % 2 == 0 && i > 0);
            if (i % 2 == 1) chk_addr(16'(i / 2));
        end

        // Flush in HOLD with ready high; redirect to 0x0010 with a 3-cycle wait.
        adv; flush = 1'b1; load_val = 16'h0010; mem_wait = 3;
        chk3(0, 0, 1);
        check("hold_instr_addr", {16'h0, instr_addr}, 32'h3);
        adv; flush = 1'b0; chk3(0, 0, 0);
        for (int i = 10; i <= 13; i++) begin
            adv; chk3(1, i == 13, 0); chk_addr(16'h0010);
        end
        push(16'hA5B5, 16'h0010);

        // Backpressure for 5 cycles.
        for (int i = 14; i <= 18; i++) begin
            adv; instr_ready = 1'b0; mem_wait = 2;
            chk3(0, 0, 1);
            check("bp_instr", {16'h0, instr}, 32'hA5B5);
            check("bp_instr_addr", {16'h0, instr_addr}, 32'h0010);
        end
        adv; instr_ready = 1'b1; chk3(0, 0, 1);

        // Flush in REQ before ack: DROP drains the old address.
        adv; flush = 1'b1; load_val = 16'h0200; chk3(1, 0, 0); chk_addr(16'h0011);
        adv; flush = 1'b0; chk3(1, 0, 0); chk_addr(16'h0011);
        adv; chk3(1, 0, 0); chk_addr(16'h0011);
        adv; mem_wait = 0; chk3(0, 0, 0);

        // Flush coincident with ack.
        adv; flush = 1'b1; load_val = 16'h0300; chk3(1, 0, 0); chk_addr(16'h0200);
        adv; flush = 1'b0; chk3(0, 0, 0);
        adv; push(16'hA6A5, 16'h0300); chk3(1, 1, 0); chk_addr(16'h0300);
        adv; chk3(0, 0, 1);

        // Reset while in REQ.
        adv; reset = 1'b1; chk3(1, 1, 0); chk_addr(16'h0301);
        adv; reset = 1'b0; chk3(0, 0, 0);
        check("rreq_instr", {16'h0, instr}, 32'h0);
        check("rreq_instr_addr", {16'h0, instr_addr}, 32'h0);
        adv; chk3(1, 1, 0); chk_addr(16'h0000);

        // Reset while in HOLD.
        adv; reset = 1'b1; instr_ready = 1'b0; chk3(0, 0, 1);
        check("rhold_pre_instr", {16'h0, instr}, 32'hA5A5);
        adv; reset = 1'b0; instr_ready = 1'b1; chk3(0, 0, 0);
        check("rhold_instr", {16'h0, instr}, 32'h0);
        adv; push(16'hA5A5, 16'h0000); chk3(1, 1, 0); chk_addr(16'h0000);
        adv; chk3(0, 0, 1);

        // Redirect to 0xFFFF and wrap to 0x0000.
        adv; flush = 1'b1; load_val = 16'hFFFF; chk3(1, 0, 0); chk_addr(16'h0001);
        adv; flush = 1'b0; chk3(0, 0, 0);
        adv; push(16'h5A5A, 16'hFFFF); chk3(1, 1, 0); chk_addr(16'hFFFF);
        adv; push(16'hA5A5, 16'h0000); chk3(0, 0, 1);
        adv; chk3(1, 1, 0); chk_addr(16'h0000);
        adv; chk3(0, 0, 1);
        adv; instr_ready = 1'b0;
        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
